// File: rtl/axis_video_tp_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_video_tp_gen_if
//  Purpose  : AXI4-Stream video bus between the test-pattern source and its
//             sink. TUSER[0] carries start-of-frame and TLAST end-of-line.
//  Signals  : tdata  [DATA_W] pixel value
//             tvalid          beat valid (source -> sink)
//             tready          sink ready (sink -> source)
//             tuser           start of frame, first pixel only
//             tlast           end of line, last pixel of each line
//  Modports : master (pattern source), slave (pixel sink)
//  Revision : 1.0  initial release
// ============================================================================
interface axis_video_tp_gen_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

`default_nettype wire

// File: rtl/axis_video_tp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axis_video_tp_gen
//  Purpose  : AXI4-Stream video test-pattern source. Emits frames of
//             cfg_width x cfg_height pixels with SOF on TUSER and EOL on
//             TLAST, optional inter-line blanking and full backpressure.
//             Configuration is sampled only at frame start; dropping the
//             enable lets the running frame complete.
//  Ports    : clk, rstn       clock, synchronous active-low reset
//             cfg_enable      run request (asynchronous, synchronised here)
//             cfg_type        0 x ramp, 1 y ramp, 2 checkerboard,
//                             3 frame_cnt + x
//             cfg_width       pixels per line
//             cfg_height      lines per frame
//             cfg_hblank      TVALID-low cycles after each non-final TLAST
//             m_axis          AXI4-Stream master (tdata/tvalid/tready/
//                             tuser/tlast)
//             busy            high whenever the generator is not idle
//             cfg_err         one-cycle pulse when a zero-sized frame is
//                             refused
//             frame_cnt       completed frames, wraps modulo 256
//  Revision : 1.0  initial release
// ============================================================================
module axis_video_tp_gen #(
  parameter int DATA_W   = 8,
  parameter int DIM_W    = 12,
  parameter int BLANK_W  = 8,
  parameter int CHK_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_enable,
  input  logic [1:0]          cfg_type,
  input  logic [DIM_W-1:0]    cfg_width,
  input  logic [DIM_W-1:0]    cfg_height,
  input  logic [BLANK_W-1:0]  cfg_hblank,
  axis_video_tp_gen_if.master m_axis,
  output logic                busy,
  output logic                cfg_err,
  output logic [7:0]          frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2,
    S_HBLANK = 2'd3
  } state_t;

  localparam logic [1:0] PAT_XRAMP = 2'd0;
  localparam logic [1:0] PAT_YRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q,      state_d;
  logic               en_meta_q;
  logic               en_q;

  // Shadow configuration, only written in LOAD
  logic [1:0]         type_q,       type_d;
  logic [DIM_W-1:0]   width_q,      width_d;
  logic [DIM_W-1:0]   height_q,     height_d;
  logic [BLANK_W-1:0] hblank_q,     hblank_d;

  // Coordinates of the next pixel to be placed in the output register
  logic [DIM_W-1:0]   x_q,          x_d;
  logic [DIM_W-1:0]   y_q,          y_d;
  logic [BLANK_W-1:0] blank_cnt_q,  blank_cnt_d;
  // The beat in the output register is the last pixel of the frame
  logic               frame_last_q, frame_last_d;

  // Output register
  logic [DATA_W-1:0]  tdata_q,      tdata_d;
  logic               tvalid_q,     tvalid_d;
  logic               tuser_q,      tuser_d;
  logic               tlast_q,      tlast_d;

  logic               cfg_err_q,    cfg_err_d;
  logic [7:0]         frame_cnt_q,  frame_cnt_d;

  // --------------------------------------------------------------------------
  // Pixel pattern for coordinate (x, y)
  // --------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] pixel(
    input logic [1:0]       t,
    input logic [DIM_W-1:0] x,
    input logic [DIM_W-1:0] y,
    input logic [7:0]       fc
  );
    logic [DATA_W-1:0] r;
    case (t)
      PAT_XRAMP: r = DATA_W'(x);
      PAT_YRAMP: r = DATA_W'(y);
      PAT_CHECK: r = {DATA_W{x[CHK_LOG2] ^ y[CHK_LOG2]}};
      default:   r = DATA_W'(fc) + DATA_W'(x);
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  logic load_en;     // output register may take a new value this cycle
  logic hold_eol;    // current beat ends a line that needs a pause after it
  logic load_beat;   // place pixel (x_q, y_q) into the output register
  logic x_at_end;
  logic y_at_end;

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    width_d      = width_q;
    height_d     = height_q;
    hblank_d     = hblank_q;
    x_d          = x_q;
    y_d          = y_q;
    blank_cnt_d  = blank_cnt_q;
    frame_last_d = frame_last_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tuser_d      = tuser_q;
    tlast_d      = tlast_q;
    cfg_err_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    load_beat    = 1'b0;

    load_en  = !tvalid_q || m_axis.tready;
    x_at_end = (x_q == width_q  - DIM_W'(1));
    y_at_end = (y_q == height_q - DIM_W'(1));
    // A TLAST beat stops the pixel pipeline until it is accepted when either
    // the frame ends there or blanking must follow it. With zero blanking the
    // next line streams on without a bubble.
    hold_eol = tvalid_q && tlast_q && (frame_last_q || (hblank_q != '0));

    case (state_q)
      S_IDLE: begin
        if (en_q) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        type_d       = cfg_type;
        width_d      = cfg_width;
        height_d     = cfg_height;
        hblank_d     = cfg_hblank;
        x_d          = '0;
        y_d          = '0;
        frame_last_d = 1'b0;
        if ((cfg_width == '0) || (cfg_height == '0)) begin
          cfg_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (load_en) begin
          if (hold_eol) begin
            // tvalid_q is high here, so load_en means the TLAST beat is taken
            tvalid_d = 1'b0;
            tuser_d  = 1'b0;
            tlast_d  = 1'b0;
            if (frame_last_q) begin
              frame_cnt_d  = frame_cnt_q + 8'd1;
              frame_last_d = 1'b0;
              state_d      = en_q ? S_LOAD : S_IDLE;
            end else begin
              blank_cnt_d  = hblank_q;
              state_d      = S_HBLANK;
            end
          end else begin
            load_beat = 1'b1;
          end
        end
      end

      S_HBLANK: begin
        // The first pixel of the next line is loaded during the last blanking
        // cycle so that TVALID is low for exactly hblank cycles.
        if (blank_cnt_q <= BLANK_W'(1)) begin
          load_beat = 1'b1;
          state_d   = S_ACTIVE;
        end else begin
          blank_cnt_d = blank_cnt_q - BLANK_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_beat) begin
      tdata_d      = pixel(type_q, x_q, y_q, frame_cnt_q);
      tvalid_d     = 1'b1;
      tuser_d      = (x_q == '0) && (y_q == '0);
      tlast_d      = x_at_end;
      frame_last_d = x_at_end && y_at_end;
      if (x_at_end) begin
        x_d = '0;
        y_d = y_at_end ? '0 : (y_q + DIM_W'(1));
      end else begin
        x_d = x_q + DIM_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      en_meta_q    <= 1'b0;
      en_q         <= 1'b0;
      type_q       <= '0;
      width_q      <= '0;
      height_q     <= '0;
      hblank_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      blank_cnt_q  <= '0;
      frame_last_q <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      cfg_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      en_meta_q    <= cfg_enable;
      en_q         <= en_meta_q;
      type_q       <= type_d;
      width_q      <= width_d;
      height_q     <= height_d;
      hblank_q     <= hblank_d;
      x_q          <= x_d;
      y_q          <= y_d;
      blank_cnt_q  <= blank_cnt_d;
      frame_last_q <= frame_last_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      cfg_err_q    <= cfg_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = (state_q != S_IDLE);
  assign cfg_err       = cfg_err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_video_tp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_video_tp_gen
//  Purpose  : Self-checking bench for axis_video_tp_gen. Expected pixels are
//             computed frame by frame from the pattern rules and queued; a
//             monitor pops one entry per accepted beat and also checks AXI
//             hold stability and blanking gaps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_video_tp_gen;

  localparam int DATA_W   = 8;
  localparam int DIM_W    = 12;
  localparam int BLANK_W  = 8;
  localparam int CHK_LOG2 = 3;

  logic               clk = 1'b0;
  logic               rstn;
  logic               cfg_enable;
  logic [1:0]         cfg_type;
  logic [DIM_W-1:0]   cfg_width;
  logic [DIM_W-1:0]   cfg_height;
  logic [BLANK_W-1:0] cfg_hblank;
  logic               busy;
  logic               cfg_err;
  logic [7:0]         frame_cnt;

  axis_video_tp_gen_if #(.DATA_W(DATA_W)) axis ();

  axis_video_tp_gen #(
    .DATA_W  (DATA_W),
    .DIM_W   (DIM_W),
    .BLANK_W (BLANK_W),
    .CHK_LOG2(CHK_LOG2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_enable(cfg_enable),
    .cfg_type  (cfg_type),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .cfg_hblank(cfg_hblank),
    .m_axis    (axis),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       last;
    int         gap;   // after a TLAST: hblank, -1 frame end; -2 otherwise
  } beat_t;

  beat_t exp_q[$];
  int    checks     = 0;
  int    errors     = 0;
  int    accepted   = 0;
  int    model_fc   = 0;
  int    ready_mode = 0;   // 0 always ready, 1 random 50%
  bit    stall_req  = 1'b0;
  int    err_pulses = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pixel value straight from the pattern definitions
  function automatic logic [7:0] ref_pix(input int t, input int x, input int y, input int fc);
    int sq;
    sq = 1 << CHK_LOG2;
    case (t)
      0:       return 8'(x % 256);
      1:       return 8'(y % 256);
      2:       return ((((x / sq) ^ (y / sq)) & 1) != 0) ? 8'hFF : 8'h00;
      default: return 8'((fc + x) % 256);
    endcase
  endfunction

  task automatic push_frames(input int t, input int w, input int h, input int hb, input int n);
    beat_t b;
    for (int f = 0; f < n; f++) begin
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          b.data = ref_pix(t, x, y, model_fc);
          b.user = (x == 0) && (y == 0);
          b.last = (x == w - 1);
          b.gap  = (x != w - 1) ? -2 : ((y == h - 1) ? -1 : hb);
          exp_q.push_back(b);
        end
      end
      model_fc = (model_fc + 1) % 256;
    end
  endtask

  // tready driver, changes just after the active edge
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req)            axis.tready = 1'b0;
      else if (ready_mode == 0) axis.tready = 1'b1;
      else                      axis.tready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard
  initial begin
    bit         prev_stall;
    logic [7:0] pd;
    logic       pu;
    logic       pl;
    int         gap_cnt;
    int         gap_exp;
    beat_t      e;
    prev_stall = 1'b0;
    pd = '0; pu = 1'b0; pl = 1'b0;
    gap_cnt = 0;
    gap_exp = -2;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
        gap_exp    = -2;
      end else begin
        if (cfg_err) err_pulses++;
        if (!busy && !axis.tvalid) gap_exp = -2;
        if (prev_stall) begin
          chk(axis.tvalid === 1'b1 && axis.tdata === pd && axis.tuser === pu && axis.tlast === pl,
              "hold_stable", {axis.tvalid, axis.tuser, axis.tlast, axis.tdata},
              {1'b1, pu, pl, pd});
        end
        if (axis.tvalid) begin
          if (gap_exp >= 0)       chk(gap_cnt == gap_exp, "hblank_gap", gap_cnt, gap_exp);
          else if (gap_exp == -1) chk(gap_cnt <= 2, "frame_gap", gap_cnt, 2);
          gap_exp = -2;
        end else if (gap_exp != -2) begin
          gap_cnt++;
        end
        if (axis.tvalid && axis.tready) begin
          accepted++;
          if (exp_q.size() == 0) begin
            chk(1'b0, "extra_beat", axis.tdata, -1);
          end else begin
            e = exp_q.pop_front();
            chk(axis.tdata === e.data, "tdata", axis.tdata, e.data);
            chk(axis.tuser === e.user, "tuser", axis.tuser, e.user);
            chk(axis.tlast === e.last, "tlast", axis.tlast, e.last);
            if (e.last) begin
              gap_exp = e.gap;
              gap_cnt = 0;
            end
          end
        end
        prev_stall = axis.tvalid && !axis.tready;
        pd = axis.tdata; pu = axis.tuser; pl = axis.tlast;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 3000, name, exp_q.size(), 0);
  endtask

  task automatic check_idle_state(input string name);
    @(negedge clk);
    chk(busy == 1'b0,          {name, "_busy"},   busy,        0);
    chk(axis.tvalid == 1'b0,   {name, "_tvalid"}, axis.tvalid, 0);
    chk(int'(frame_cnt) == model_fc, {name, "_frame_cnt"}, frame_cnt, model_fc);
  endtask

  // Run exactly n frames: stall the sink once the last frame is loaded, drop
  // the enable, then release so that frame finishes and the DUT idles.
  task automatic run_cfg(input int t, input int w, input int h, input int hb,
                         input int n, input int rm, input string name);
    int target;
    int cyc;
    cfg_type   = 2'(t);
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    cfg_hblank = BLANK_W'(hb);
    ready_mode = rm;
    stall_req  = 1'b0;
    target     = accepted + (n - 1) * w * h;
    push_frames(t, w, h, hb, n);
    cfg_enable = 1'b1;
    cyc = 0;
    while (accepted < target && cyc < 5000) begin
      @(posedge clk); #2; cyc++;
    end
    stall_req = 1'b1;
    cyc = 0;
    while (!(busy && axis.tvalid) && cyc < 200) begin
      @(posedge clk); #2; cyc++;
    end
    chk(cyc < 200, {name, "_start"}, cyc, 0);
    cfg_enable = 1'b0;
    repeat (4) @(posedge clk);
    #2 stall_req = 1'b0;
    wait_idle({name, "_drain"});
    check_idle_state(name);
  endtask

  initial begin
    #800000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int cyc;
    rstn       = 1'b0;
    cfg_enable = 1'b0;
    cfg_type   = '0;
    cfg_width  = DIM_W'(4);
    cfg_height = DIM_W'(2);
    cfg_hblank = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(axis.tvalid == 1'b0, "rst_tvalid", axis.tvalid, 0);
    chk(axis.tuser == 1'b0 && axis.tlast == 1'b0, "rst_user_last", {axis.tuser, axis.tlast}, 0);
    chk(axis.tdata == 8'h00, "rst_tdata", axis.tdata, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(cfg_err == 1'b0, "rst_cfg_err", cfg_err, 0);
    chk(frame_cnt == 8'd0, "rst_frame_cnt", frame_cnt, 0);
    rstn = 1'b1;

    // x ramp, continuous sink, two frames back to back
    run_cfg(0, 4, 2, 0, 2, 0, "xramp");
    // y ramp under random backpressure
    run_cfg(1, 4, 2, 0, 2, 1, "yramp_bp");
    // inter-line blanking, continuous and with backpressure
    run_cfg(0, 3, 2, 5, 2, 0, "hblank");
    run_cfg(3, 3, 2, 5, 2, 1, "hblank_bp");

    // enable dropped at beat 2 of line 0; width change mid-frame is ignored
    cfg_type = 2'd3; cfg_width = DIM_W'(4); cfg_height = DIM_W'(3); cfg_hblank = '0;
    ready_mode = 0;
    base = accepted;
    push_frames(3, 4, 3, 0, 1);
    cfg_enable = 1'b1;
    cyc = 0;
    while (accepted < base + 2 && cyc < 200) begin
      @(posedge clk); #2; cyc++;
    end
    cfg_enable = 1'b0;
    cfg_width  = DIM_W'(7);
    wait_idle("disable_drain");
    check_idle_state("disable");
    chk(accepted - base == 12, "disable_beats", accepted - base, 12);
    // the new width takes effect at the next LOAD
    run_cfg(3, 7, 3, 0, 1, 1, "new_width");

    // zero-sized frame is refused repeatedly
    cfg_width = '0; cfg_height = DIM_W'(5);
    err_pulses = 0;
    cfg_enable = 1'b1;
    repeat (21) @(posedge clk);
    cfg_enable = 1'b0;
    wait_idle("zero_w_drain");
    chk(err_pulses >= 8 && err_pulses <= 14, "cfg_err_pulses", err_pulses, 10);
    check_idle_state("zero_w");

    // reset while a beat is stalled
    cfg_type = 2'd0; cfg_width = DIM_W'(8); cfg_height = DIM_W'(2); cfg_hblank = BLANK_W'(1);
    ready_mode = 1;
    base = accepted;
    push_frames(0, 8, 2, 1, 1);
    cfg_enable = 1'b1;
    cyc = 0;
    while (accepted < base + 3 && cyc < 500) begin
      @(posedge clk); #2; cyc++;
    end
    stall_req = 1'b1;
    cyc = 0;
    while (!axis.tvalid && cyc < 50) begin
      @(posedge clk); #2; cyc++;
    end
    chk(axis.tvalid == 1'b1, "pre_rst_stall", axis.tvalid, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    cfg_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(axis.tvalid == 1'b0, "midrst_tvalid", axis.tvalid, 0);
    chk(frame_cnt == 8'd0, "midrst_frame_cnt", frame_cnt, 0);
    chk(busy == 1'b0, "midrst_busy", busy, 0);
    exp_q.delete();
    model_fc = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    stall_req = 1'b0;

    // restart with the checkerboard, 8-pixel squares
    run_cfg(2, 16, 2, 0, 1, 0, "checker");

    // single-pixel and single-line boundaries
    run_cfg(1, 1, 3, 2, 2, 1, "w1");
    run_cfg(3, 5, 1, 3, 2, 1, "h1");
    run_cfg(0, 1, 1, 1, 3, 1, "w1h1");

    // randomised configurations
    for (int i = 0; i < 6; i++) begin
      run_cfg($urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(1, 4),
              $urandom_range(0, 3), 2, 1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
